// File: rtl/insert_y.sv
// rtl/insert_y.sv - accumulates the 14 y check digits over an 84-digit data word and inserts them to form the 98-digit word
module insert_y #(
    parameter int N     = 98,
    parameter int M     = 84,
    parameter int LANES = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*M-1:0]   word_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   word_out
);

    localparam int Y     = N - M;
    localparam int YW    = $clog2(Y);
    localparam int STEPS = M / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (N != 98 || M != 84) begin : g_bad_size
        $error("insert_y: only N=98, M=84 is supported");
    end
    if ((M % LANES) != 0 || !(LANES == 1 || LANES == 2 || LANES == 7 || LANES == 14)) begin : g_bad_lanes
        $error("insert_y: LANES must be 1, 2, 7 or 14");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*M-1:0]      word_q, word_d;
    logic [Y-1:0][1:0]   acc_q, acc_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [2*N-1:0]      word_out_q, word_out_d;

    logic [Y-1:0][1:0]   acc_next;
    logic [2*N-1:0]      assembled;

    // Lane l folds data digit cnt*LANES+l into y[digit mod 14]; 2-bit sums wrap mod 4.
    always_comb begin
        acc_next = acc_q;
        for (int l = 0; l < LANES; l++) begin
            int k;
            k = int'(cnt_q) * LANES + l;
            acc_next[YW'(k % Y)] = acc_next[YW'(k % Y)] + word_q[2*k +: 2];
        end
    end

    // Fixed digit map: y digits at 0..5, 14..16, 62..64, 96..97; data fills the rest in order.
    always_comb begin
        assembled = '0;
        for (int i = 0; i < 6; i++)  assembled[2*i +: 2]        = acc_next[i];
        for (int i = 0; i < 8; i++)  assembled[2*(6+i) +: 2]    = word_q[2*i +: 2];
        for (int i = 0; i < 3; i++)  assembled[2*(14+i) +: 2]   = acc_next[6+i];
        for (int i = 0; i < 45; i++) assembled[2*(17+i) +: 2]   = word_q[2*(8+i) +: 2];
        for (int i = 0; i < 3; i++)  assembled[2*(62+i) +: 2]   = acc_next[9+i];
        for (int i = 0; i < 31; i++) assembled[2*(65+i) +: 2]   = word_q[2*(53+i) +: 2];
        for (int i = 0; i < 2; i++)  assembled[2*(96+i) +: 2]   = acc_next[12+i];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        acc_d       = acc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        word_out_d  = word_out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    word_d     = word_in;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_ACCUM;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_ACCUM: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) begin
                    cnt_d       = '0;
                    word_out_d  = assembled;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            word_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            word_out_q  <= word_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign word_out  = word_out_q;

endmodule
